// File: rtl/atpg_entry_ctl.sv
// Purpose: qualify TST, accept a serial unlock key on SCL/SDA, then hold ATPG scan mode.
// Latency: scan mode asserts 2 clk after the 16th synchronized SCL rise.
// Backpressure: none; pads are free-running, and bad keys count toward a permanent lockout.
`timescale 1ns/1ps
module atpg_entry_ctl #(
  parameter int               KEY_W   = 16,
  parameter logic [KEY_W-1:0] KEY     = 16'hA5C3,
  parameter int               DEB     = 4,
  parameter int               TMO     = 255,
  parameter int               MAX_ERR = 3
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       i_tst,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_gpio_ts,
  output logic       o_scan_mode,
  output logic       o_scan_en,
  output logic       o_locked,
  output logic [1:0] o_err_cnt
);

  localparam int DW = $clog2(DEB + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam int BW = $clog2(KEY_W + 1);
  localparam logic [DW-1:0] LP_DEB      = DW'(DEB);
  localparam logic [TW-1:0] LP_TMO      = TW'(TMO);
  localparam logic [BW-1:0] LP_BIT_LAST = BW'(KEY_W - 1);
  localparam logic [1:0]    LP_MAX      = 2'(MAX_ERR);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT, ST_CHECK, ST_SCAN, ST_WAITLO, ST_LOCK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_tst_m, r_tst_s;
  logic             r_scl_m, r_scl_s, r_scl_d;
  logic             r_sda_m, r_sda_s;
  logic [DW-1:0]    r_deb_cnt;
  logic [TW-1:0]    r_tmo_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [KEY_W-1:0] r_sr;
  logic [1:0]       r_err_cnt;
  logic             r_scan_mode;
  logic             r_locked;
  logic             w_scl_rise;
  logic             w_deb_tgt;
  logic             w_deb_ok;
  logic             w_shift;
  logic             w_fail;
  logic             w_pass;
  logic [1:0]       w_err_inc;

  assign w_scl_rise = r_scl_s & ~r_scl_d;
  // IDLE qualifies TST high; every other state that looks at TST wants it low.
  assign w_deb_tgt  = (r_state == ST_IDLE);
  assign w_deb_ok   = (r_deb_cnt == LP_DEB);
  assign w_err_inc  = r_err_cnt + 2'd1;

  // Two-flop synchronizers for the asynchronous pads, plus the SCL edge-detect flop.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_tst_m <= 1'b0; r_tst_s <= 1'b0;
      r_scl_m <= 1'b0; r_scl_s <= 1'b0; r_scl_d <= 1'b0;
      r_sda_m <= 1'b0; r_sda_s <= 1'b0;
    end else begin
      r_tst_m <= i_tst; r_tst_s <= r_tst_m;
      r_scl_m <= i_scl; r_scl_s <= r_scl_m; r_scl_d <= r_scl_s;
      r_sda_m <= i_sda; r_sda_s <= r_sda_m;
    end
  end

  // Next-state decode; a failed attempt goes to LOCK once the error budget is spent.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_fail      = 1'b0;
    w_pass      = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_deb_ok) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        // TST dropping aborts immediately and beats a coincident SCL rise.
        if (!r_tst_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_scl_rise) begin
          w_shift = 1'b1;
          if (r_bit_cnt == LP_BIT_LAST) w_state_nxt = ST_CHECK;
        end else if (r_tmo_cnt == LP_TMO) begin
          w_fail = 1'b1;
        end
      end
      ST_CHECK: begin
        if (r_sr == KEY) begin
          w_pass      = 1'b1;
          w_state_nxt = ST_SCAN;
        end else begin
          w_fail = 1'b1;
        end
      end
      ST_SCAN:   if (w_deb_ok) w_state_nxt = ST_IDLE;
      ST_WAITLO: if (w_deb_ok) w_state_nxt = ST_IDLE;
      ST_LOCK:   w_state_nxt = ST_LOCK;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_fail) w_state_nxt = (w_err_inc == LP_MAX) ? ST_LOCK : ST_WAITLO;
  end

  // State register and registered outputs, both derived from the next state.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state     <= ST_IDLE;
      r_scan_mode <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_scan_mode <= (w_state_nxt == ST_SCAN);
      r_locked    <= (w_state_nxt == ST_LOCK);
    end
  end

  // TST debounce; restarts on every state change so a stale count never qualifies.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_deb_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_deb_cnt <= '0;
    end else if (r_tst_s != w_deb_tgt) begin
      r_deb_cnt <= '0;
    end else if (!w_deb_ok) begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // Key shift register, bit counter and inter-edge timeout.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_tmo_cnt <= '0;
    end else if (r_state == ST_IDLE && w_state_nxt == ST_SHIFT) begin
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_tmo_cnt <= '0;
    end else if (r_state == ST_SHIFT) begin
      if (w_shift) begin
        r_sr      <= {r_sr[KEY_W-2:0], r_sda_s};
        r_bit_cnt <= r_bit_cnt + 1'b1;
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt != LP_TMO) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  // Failed-attempt counter: saturating, cleared by a successful entry.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_err_cnt <= 2'd0;
    end else if (w_pass) begin
      r_err_cnt <= 2'd0;
    end else if (w_fail && r_err_cnt != LP_MAX) begin
      r_err_cnt <= w_err_inc;
    end
  end

  assign o_scan_mode = r_scan_mode;
  assign o_scan_en   = r_scan_mode & i_gpio_ts;
  assign o_locked    = r_locked;
  assign o_err_cnt   = r_err_cnt;

endmodule
